muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer for the pipelined core's HI/LO instructions: mult, multu, div, divu, mthi, mtlo.
- It borrows the shared 32-bit ALU for one add or sub per iteration and returns the 64-bit result in HI/LO.
- It asserts busy so the hazard unit stalls any mfhi/mflo or muldiv instruction until the result is ready.

Parameters:
- XLEN, 32, operand width; the iteration count equals XLEN.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  launch an operation; sampled only while idle.
- op  in  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
- rs_val  in  XLEN  multiplicand or dividend.
- rt_val  in  XLEN  multiplier or divisor.
- hi_we  in  1  mthi write enable.
- lo_we  in  1  mtlo write enable.
- wdata  in  XLEN  mthi/mtlo data.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse when the result is written.
- hi  out  XLEN  HI register.
- lo  out  XLEN  LO register.
- alu_req  out  1  sequencer owns the ALU this cycle.
- alu_a  out  XLEN  ALU operand A.
- alu_b  out  XLEN  ALU operand B.
- alu_ctr  out  4  ALU opcode.
- alu_c  in  XLEN  ALU result; combinational, valid in the same cycle.

Interface is decided: one clock; reset is synchronous and active-high; clock port clk, reset port rst.

Behaviour:
- Reset (any cycle, including mid-operation): state IDLE, busy=0, done=0, hi=lo=0, alu_req=0, alu_a=alu_b=0, alu_ctr=4'b0000. The in-flight operation is discarded and no done pulse is issued.
- States: IDLE -> PREP -> ITER (XLEN cycles, counter 0..XLEN-1) -> FIX -> IDLE.
- busy = (state != IDLE).
- done is registered and is high in the first IDLE cycle after FIX.
- Latency: start sampled at edge T; PREP during T+1, ITER during T+2..T+33, FIX during T+34. hi/lo updated and done=1 in cycle T+35.
- Entry from IDLE: start=1 enters PREP, latching op, rs_val and rt_val.
- Start while busy: ignored, no queueing.
- PREP:
  - Signed ops (mult, div): take the absolute value of each operand locally; record sign_q = rs[31]^rt[31] and sign_r = rs[31].
  - Unsigned ops: sign_q = sign_r = 0.
  - Clear the 64-bit accumulator and the 33rd-bit flag.
- ITER, multiply (shift-add, LSB-first). Accumulator is {P_hi, P_lo}, with P_lo initialised to the multiplier.
  - If P_lo[0]=1: alu_a=P_hi, alu_b=mcand, alu_ctr=ALU_add. carry=(alu_c < P_hi) unsigned. Next {P_hi,P_lo} = {carry, alu_c, P_lo} >> 1.
  - Otherwise: shift {0, P_hi, P_lo} right by 1. alu_ctr=ALU_add is still driven, result unused.
- ITER, divide (restoring, MSB-first). Quotient shifts into Q.
  - Shift {R, Q} left by 1; the bit shifted out of R is msb.
  - alu_a = shifted R, alu_b = divisor, alu_ctr = ALU_sub.
  - If msb=1 or shifted R >= divisor: R = alu_c, q bit = 1. Otherwise R unchanged, q bit = 0.
- alu_req=1 only in ITER. Outside ITER, alu_a, alu_b and alu_ctr are 0.
- FIX:
  - Multiply: if sign_q=1, 64-bit two's-complement negate of {P_hi,P_lo}; then hi=P_hi, lo=P_lo.
  - Divide: lo = sign_q ? -Q : Q; hi = sign_r ? -R : R.
  - Sign fix-up is local arithmetic and never uses the ALU.
- Divide by zero: hi=rs_val as latched (raw), lo=32'hFFFF_FFFF, same latency, no exception.
- INT_MIN cases:
  - mult/div INT_MIN operands: abs(0x80000000) is treated as unsigned 2^31.
  - div 0x80000000 / -1: lo=0x80000000, hi=0.
- mthi/mtlo: when idle, hi_we/lo_we write wdata at the next edge.
  - Ignored while busy; the pipeline must stall.
  - If start and a write are both asserted in IDLE, start wins and the write is dropped.

Optional Feature:
- Macro: MULDIV_EARLY_EXIT_EN.
- Defined: a multiply leaves ITER once the remaining unshifted multiplier bits are all zero. Before entering FIX, it applies the outstanding right-shift of {P_hi,P_lo} in one step. Latency is variable, minimum 3 cycles (PREP, FIX, done); busy covers the whole span. Divide is unaffected.
- Undefined: fixed XLEN-iteration latency as above.

Decomposition:
- Shared package muldiv_pkg holds:
  - ALU opcode constants ALU_add=4'b0001 and ALU_sub=4'b0010, which must match the ALU decode.
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - State encoding IDLE, PREP, ITER, FIX.
- One sub-module: muldiv_sign_fix, combinational. Provides 32-bit conditional absolute value and 64-bit/32-bit conditional negate; used in PREP and FIX.

Test Plan:
- multu 0xFFFFFFFF x 0xFFFFFFFF, start at T -> busy T+1..T+34; done at T+35; hi=0xFFFFFFFE, lo=0x00000001.
- mult 0xFFFFFFFD (-3) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; alu_ctr=4'b0001 whenever alu_req=1.
- div 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 0x80000000 / 3 -> lo=0x2AAAAAAA, hi=2.
- divu 100 / 0 -> hi=0x00000064, lo=0xFFFFFFFF, done at T+35.
- rst=1 at T+10 -> at T+11 busy=0, hi=lo=0, and no done pulse follows. start pulsed at T+5 during an operation -> ignored; only one done.
- Idle hi_we=1, wdata=0x1234 -> hi=0x1234 next cycle. Same write while busy -> hi unchanged. With MULDIV_EARLY_EXIT_EN, multu 5 x 3 -> lo=15, done well before T+35.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants for the HI/LO multiply/divide sequencer: ALU opcodes,
// operation encodings and sequencer states.
package muldiv_pkg;

  localparam logic [3:0] ALU_add = 4'b0001;
  localparam logic [3:0] ALU_sub = 4'b0010;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PREP = 2'b01,
    ITER = 2'b10,
    FIX  = 2'b11
  } state_t;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational sign helpers: two conditional absolute values, one 64-bit and
// two 32-bit conditional negates. Shared by the PREP and FIX steps.
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0]   abs_a_in,
  input  logic [W-1:0]   abs_b_in,
  input  logic           abs_en,
  output logic [W-1:0]   abs_a_out,
  output logic [W-1:0]   abs_b_out,
  input  logic [2*W-1:0] n64_in,
  input  logic           n64_en,
  output logic [2*W-1:0] n64_out,
  input  logic [W-1:0]   n32a_in,
  input  logic           n32a_en,
  output logic [W-1:0]   n32a_out,
  input  logic [W-1:0]   n32b_in,
  input  logic           n32b_en,
  output logic [W-1:0]   n32b_out
);

  // abs of the most negative value wraps to itself, which read unsigned is 2^(W-1)
  assign abs_a_out = (abs_en && abs_a_in[W-1]) ? (~abs_a_in + 1'b1) : abs_a_in;
  assign abs_b_out = (abs_en && abs_b_in[W-1]) ? (~abs_b_in + 1'b1) : abs_b_in;
  assign n64_out   = n64_en  ? (~n64_in  + 1'b1) : n64_in;
  assign n32a_out  = n32a_en ? (~n32a_in + 1'b1) : n32a_in;
  assign n32b_out  = n32b_en ? (~n32b_in + 1'b1) : n32b_in;

endmodule

// File: rtl/muldiv_seq.sv
// Iterative mult/multu/div/divu sequencer with HI/LO and mthi/mtlo, borrowing
// the shared ALU once per iteration. MULDIV_EARLY_EXIT_EN: multiply early exit.
import muldiv_pkg::*;

module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            alu_req,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_ctr,
  input  logic [XLEN-1:0] alu_c
);

  localparam int CW = $clog2(XLEN);

  state_t          state, state_n;
  op_t             op_q, op_n;
  logic [XLEN-1:0] rs_q, rs_n, rt_q, rt_n, bop, bop_n;
  logic [XLEN-1:0] acc_hi, acc_hi_n, acc_lo, acc_lo_n;
  logic [XLEN-1:0] hi_r, hi_n, lo_r, lo_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            sign_q, sign_q_n, sign_r, sign_r_n, done_r, done_n;
  logic            signed_op, is_div, carry, msb, take;
  logic [XLEN-1:0] rsh, abs_rs, abs_rt, neg_q, neg_r;
  logic [2*XLEN-1:0] neg_p;
`ifdef MULDIV_EARLY_EXIT_EN
  logic [XLEN-1:0] mrem, mrem_n;
  logic [CW:0]     sh;
`endif

  assign signed_op = (op_q == OP_MULT) || (op_q == OP_DIV);
  assign is_div    = op_q[1];

  muldiv_sign_fix #(.W(XLEN)) u_sign_fix (
    .abs_a_in (rs_q),             .abs_b_in (rt_q),   .abs_en  (signed_op),
    .abs_a_out(abs_rs),           .abs_b_out(abs_rt),
    .n64_in   ({acc_hi, acc_lo}), .n64_en   (sign_q), .n64_out (neg_p),
    .n32a_in  (acc_lo),           .n32a_en  (sign_q), .n32a_out(neg_q),
    .n32b_in  (acc_hi),           .n32b_en  (sign_r), .n32b_out(neg_r)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= OP_MULT;
      rs_q   <= '0;
      rt_q   <= '0;
      bop    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      cnt    <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      done_r <= 1'b0;
`ifdef MULDIV_EARLY_EXIT_EN
      mrem   <= '0;
`endif
    end else begin
      state  <= state_n;
      op_q   <= op_n;
      rs_q   <= rs_n;
      rt_q   <= rt_n;
      bop    <= bop_n;
      acc_hi <= acc_hi_n;
      acc_lo <= acc_lo_n;
      hi_r   <= hi_n;
      lo_r   <= lo_n;
      cnt    <= cnt_n;
      sign_q <= sign_q_n;
      sign_r <= sign_r_n;
      done_r <= done_n;
`ifdef MULDIV_EARLY_EXIT_EN
      mrem   <= mrem_n;
`endif
    end
  end

  always_comb begin
    state_n  = state;
    op_n     = op_q;
    rs_n     = rs_q;
    rt_n     = rt_q;
    bop_n    = bop;
    acc_hi_n = acc_hi;
    acc_lo_n = acc_lo;
    hi_n     = hi_r;
    lo_n     = lo_r;
    cnt_n    = cnt;
    sign_q_n = sign_q;
    sign_r_n = sign_r;
    done_n   = 1'b0;
    alu_req  = 1'b0;
    alu_a    = '0;
    alu_b    = '0;
    alu_ctr  = 4'b0000;
    carry    = 1'b0;
    msb      = acc_hi[XLEN-1];
    rsh      = {acc_hi[XLEN-2:0], acc_lo[XLEN-1]};
    take     = 1'b0;
`ifdef MULDIV_EARLY_EXIT_EN
    mrem_n   = mrem;
    sh       = (CW+1)'(XLEN) - {1'b0, cnt};
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_n = PREP;
          op_n    = op_t'(op);
          rs_n    = rs_val;
          rt_n    = rt_val;
        end else begin
          if (hi_we) hi_n = wdata;
          if (lo_we) lo_n = wdata;
        end
      end
      PREP: begin
        state_n  = ITER;
        sign_q_n = signed_op & (rs_q[XLEN-1] ^ rt_q[XLEN-1]);
        sign_r_n = signed_op & rs_q[XLEN-1];
        cnt_n    = '0;
        acc_hi_n = '0;
        acc_lo_n = is_div ? abs_rs : abs_rt;
        bop_n    = is_div ? abs_rt : abs_rs;
`ifdef MULDIV_EARLY_EXIT_EN
        mrem_n   = abs_rt;
        if (!is_div && abs_rt == '0) state_n = FIX;
`endif
      end
      ITER: begin
        alu_req = 1'b1;
        alu_b   = bop;
        cnt_n   = cnt + 1'b1;
        if (cnt == CW'(XLEN - 1)) state_n = FIX;
        if (is_div) begin
          alu_a    = rsh;
          alu_ctr  = ALU_sub;
          take     = msb | (rsh >= bop);
          acc_hi_n = take ? alu_c : rsh;
          acc_lo_n = {acc_lo[XLEN-2:0], take};
        end else begin
          alu_a   = acc_hi;
          alu_ctr = ALU_add;
          if (acc_lo[0]) begin
            carry    = alu_c < acc_hi;
            acc_hi_n = {carry, alu_c[XLEN-1:1]};
            acc_lo_n = {alu_c[0], acc_lo[XLEN-1:1]};
          end else begin
            acc_hi_n = {1'b0, acc_hi[XLEN-1:1]};
            acc_lo_n = {acc_hi[0], acc_lo[XLEN-1:1]};
          end
`ifdef MULDIV_EARLY_EXIT_EN
          mrem_n = mrem >> 1;
          // no multiplier bits left: the rest of the iterations are pure shifts
          if (mrem == '0) begin
            {acc_hi_n, acc_lo_n} = {acc_hi, acc_lo} >> sh;
            state_n              = FIX;
          end
`endif
        end
      end
      FIX: begin
        state_n = IDLE;
        done_n  = 1'b1;
        if (!is_div) begin
          {hi_n, lo_n} = neg_p;
        end else if (rt_q == '0) begin
          hi_n = rs_q;
          lo_n = '1;
        end else begin
          hi_n = neg_r;
          lo_n = neg_q;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed and random ops against an
// arithmetic reference model, with a behavioural ALU stub.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val, wdata;
  logic        busy, done, alu_req;
  logic [31:0] hi, lo, alu_a, alu_b, alu_c;
  logic [3:0]  alu_ctr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign alu_c = (alu_ctr == 4'b0001) ? alu_a + alu_b :
                 (alu_ctr == 4'b0010) ? alu_a - alu_b : 32'h0;

  muldiv_seq #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .alu_req(alu_req), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctr(alu_ctr), .alu_c(alu_c)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {hi, lo} from the architectural definition of each op
  function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    int     ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = $signed(a);
    ib = $signed(b);
    case (o)
      2'b00: return 64'(sa * sb);
      2'b01: return {32'h0, a} * {32'h0, b};
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(ia % ib), 32'(ia / ib)};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit poke);
    logic [63:0] exp;
    int  done_k, ndone, nreq;
    bit  busy_bad, alu_bad;
    exp = ref_res(o, a, b);
    done_k = 0; ndone = 0; nreq = 0; busy_bad = 0; alu_bad = 0;
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke && k == 5) begin
        start = 1'b1; op = 2'($urandom); rs_val = $urandom; rt_val = $urandom;
      end
      if (done) begin
        ndone++;
        if (done_k == 0) done_k = k;
      end
      if (busy !== (done_k == 0)) busy_bad = 1;
      if (alu_req) begin
        nreq++;
        if (alu_ctr !== (o[1] ? 4'b0010 : 4'b0001)) alu_bad = 1;
      end else if ({alu_a, alu_b, alu_ctr} !== 68'h0) alu_bad = 1;
    end
`ifdef MULDIV_EARLY_EXIT_EN
    if (o[1]) begin
      chk({tag, " latency"}, done_k, 35);
      chk({tag, " alu_cycles"}, nreq, 32);
    end else begin
      chk({tag, " latency_bound"}, (done_k >= 3 && done_k <= 35), 1);
    end
`else
    chk({tag, " latency"}, done_k, 35);
    chk({tag, " alu_cycles"}, nreq, 32);
`endif
    chk({tag, " done_count"}, ndone, 1);
    chk({tag, " busy"}, busy_bad, 0);
    chk({tag, " alu_port"}, alu_bad, 0);
    chk({tag, " hilo"}, {hi, lo}, exp);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb, hold;
    int          ndone;
    rst = 1'b1; start = 1'b0; op = 2'b00; rs_val = 0; rt_val = 0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = 0;
    repeat (2) @(negedge clk);
    chk("reset outputs", {busy, done, alu_req, hi, lo}, 67'h0);
    chk("reset alu", {alu_a, alu_b, alu_ctr}, 68'h0);
    rst = 1'b0;

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    chk("multu_max const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op("mult_neg3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, 0);
    chk("mult_neg3x7 const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("div_neg7by2", 2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    chk("div_neg7by2 const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu_min_by3", 2'b11, 32'h8000_0000, 32'd3, 0);
    chk("divu_min_by3 const", {hi, lo}, 64'h0000_0002_2AAA_AAAA);
    run_op("divu_by0", 2'b11, 32'd100, 32'd0, 0);
    chk("divu_by0 const", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
    run_op("div_min_by_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("mult_min_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 0);
    run_op("start_ignored", 2'b00, 32'd12345, 32'hFFFF_0001, 1);
    run_op("multu_5x3", 2'b01, 32'd5, 32'd3, 0);

    for (int i = 0; i < 14; i++) begin
      ro = 2'($urandom); ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 0;
        1: ra = 32'h8000_0000;
        2: rb = 32'hFFFF_FFFF;
        3: rb = $urandom_range(1, 15);
        default: ;
      endcase
      run_op($sformatf("rand%0d", i), ro, ra, rb, 0);
    end

    // reset in the middle of an operation
    @(negedge clk);
    start = 1'b1; op = 2'b01; rs_val = 32'd77; rt_val = 32'd99;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 10) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    chk("midreset state", {busy, done, hi, lo}, 66'h0);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midreset no_done", ndone, 0);

    // mthi/mtlo while idle, while busy, and colliding with start
    hi_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi idle", hi, 32'h1234);
    lo_we = 1'b1; wdata = 32'hABCD_0001;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo idle", lo, 32'hABCD_0001);
    hold = lo;
    start = 1'b1; op = 2'b01; rs_val = 32'd6; rt_val = 32'd7;
    lo_we = 1'b1; wdata = 32'h5555_5555;
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    chk("start_wins lo", lo, hold);
    hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    hi_we = 1'b0;
    @(negedge clk);
    chk("mthi busy", hi, 32'h1234);
    ndone = 0;
    for (int k = 0; k < 40 && ndone == 0; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("collide done", ndone, 1);
    chk("collide result", {hi, lo}, 64'd42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
